// File: rtl/uds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uds_pkg
//  Purpose  : Shared mode codes, FSM states and pixel-ALU opcodes for the
//             row-streaming up/down-sampler.
//  Revision : 1.0  initial release
// ============================================================================
package uds_pkg;

    localparam logic [1:0] UDS_DN_MAX   = 2'b00;
    localparam logic [1:0] UDS_DN_AVG   = 2'b01;
    localparam logic [1:0] UDS_UP_NEAR  = 2'b10;
    localparam logic [1:0] UDS_UP_BILIN = 2'b11;

    typedef enum logic [1:0] {
        S_IN    = 2'd0,
        S_EMIT2 = 2'd1,
        S_FLUSH = 2'd2
    } uds_state_t;

    typedef enum logic [1:0] {
        ALU_MAX2 = 2'd0,
        ALU_MAX4 = 2'd1,
        ALU_AVG2 = 2'd2,
        ALU_AVG4 = 2'd3
    } alu_op_t;

endpackage
`default_nettype wire

// File: rtl/uds_pix_alu.sv
`default_nettype none
// ============================================================================
//  Module   : uds_pix_alu
//  Purpose  : Combinational per-pixel max2/max4/avg2/avg4 on unsigned pixels.
//             Define UDS_ROUND_EN to round averages half-up instead of
//             truncating.
//  Revision : 1.0  initial release
// ============================================================================
module uds_pix_alu
    import uds_pkg::*;
#(
    parameter int DW = 16
) (
    input  alu_op_t       i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_res
);

`ifdef UDS_ROUND_EN
    localparam logic [DW:0]   c_RND2 = {{DW{1'b0}}, 1'b1};
    localparam logic [DW+1:0] c_RND4 = {{DW{1'b0}}, 2'b10};
`else
    localparam logic [DW:0]   c_RND2 = '0;
    localparam logic [DW+1:0] c_RND4 = '0;
`endif

    logic [DW:0]   w_sum2;
    logic [DW+1:0] w_sum4;
    logic [DW-1:0] w_max_ab;
    logic [DW-1:0] w_max_cd;

    // Sums carry enough headroom that the rounding constant can never wrap.
    assign w_sum2   = {1'b0, i_a} + {1'b0, i_b} + c_RND2;
    assign w_sum4   = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c} + {2'b00, i_d} + c_RND4;
    assign w_max_ab = (i_a > i_b) ? i_a : i_b;
    assign w_max_cd = (i_c > i_d) ? i_c : i_d;

    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_MAX2: o_res = w_max_ab;
            ALU_MAX4: o_res = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
            ALU_AVG2: o_res = DW'(w_sum2 >> 1);
            ALU_AVG4: o_res = DW'(w_sum4 >> 2);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uds_stream.sv
`default_nettype none
// ============================================================================
//  Module   : uds_stream
//  Purpose  : Row-streaming 2x up-sampler (nearest/bilinear) and 2x2 stride-2
//             down-sampler (max/avg). UDS_ROUND_EN selects rounded averages.
//  Revision : 1.0  initial release
// ============================================================================
module uds_stream
    import uds_pkg::*;
#(
    parameter int DW = 16,
    parameter int W  = 8,
    parameter int H  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [W*DW-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*W*DW-1:0]   out_data,
    output logic                out_eof,
    output logic                frame_err
);

    localparam int              c_CW    = $clog2(H);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(H-1);
    localparam int              c_DNPAD = 2*W*DW - (W/2)*DW;

    uds_state_t           r_state;
    logic [c_CW-1:0]      r_row_cnt;
    logic [1:0]           r_mode;
    logic [2*W*DW-1:0]    r_line;
    logic [2*W*DW-1:0]    r_out_data;
    logic                 r_out_valid;
    logic                 r_out_eof;
    logic                 r_frame_err;
    logic [2*W*DW-1:0]    r_pend;
    logic                 r_pend_eof;
    logic                 r_flush_next;

    logic                 w_accept;
    logic                 w_restart;
    logic [c_CW-1:0]      w_row;
    logic [1:0]           w_mode;
    logic                 w_last;
    logic                 w_dn;
    logic [2*W*DW-1:0]    w_hrow;
    logic [2*W*DW-1:0]    w_near;
    logic [2*W*DW-1:0]    w_vrow;
    logic [(W/2)*DW-1:0]  w_dn_row;

    assign in_ready  = (r_state == S_IN) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    // A sof row always starts a tile; mode is taken live only on row 0.
    assign w_restart = in_sof && (r_row_cnt != '0);
    assign w_row     = in_sof ? '0 : r_row_cnt;
    assign w_mode    = (w_row == '0) ? mode : r_mode;
    assign w_last    = (w_row == c_LAST);
    assign w_dn      = ~w_mode[1];

    for (genvar c = 0; c < W; c++) begin : g_unpack
        assign w_hrow[(2*c)*DW +: DW]   = in_data[c*DW +: DW];
        assign w_near[(2*c)*DW +: DW]   = in_data[c*DW +: DW];
        assign w_near[(2*c+1)*DW +: DW] = in_data[c*DW +: DW];
    end

    for (genvar c = 0; c < W-1; c++) begin : g_hlane
        uds_pix_alu #(.DW(DW)) u_h_alu (
            .i_op  (ALU_AVG2),
            .i_a   (in_data[c*DW +: DW]),
            .i_b   (in_data[(c+1)*DW +: DW]),
            .i_c   ('0),
            .i_d   ('0),
            .o_res (w_hrow[(2*c+1)*DW +: DW])
        );
    end
    assign w_hrow[(2*W-1)*DW +: DW] = in_data[(W-1)*DW +: DW];

    // Low lanes serve both the 2x2 window (down) and the vertical blend (up).
    for (genvar j = 0; j < 2*W; j++) begin : g_vlane
        alu_op_t       w_op;
        logic [DW-1:0] w_a;
        logic [DW-1:0] w_b;
        logic [DW-1:0] w_c;
        logic [DW-1:0] w_d;
        if (j < W/2) begin : g_dn_lane
            assign w_op = w_dn ? (w_mode[0] ? ALU_AVG4 : ALU_MAX4) : ALU_AVG2;
            assign w_a  = w_dn ? r_line[(2*j)*DW +: DW]   : r_line[j*DW +: DW];
            assign w_b  = w_dn ? r_line[(2*j+1)*DW +: DW] : w_hrow[j*DW +: DW];
            assign w_c  = in_data[(2*j)*DW +: DW];
            assign w_d  = in_data[(2*j+1)*DW +: DW];
            assign w_dn_row[j*DW +: DW] = w_vrow[j*DW +: DW];
        end else begin : g_up_lane
            assign w_op = ALU_AVG2;
            assign w_a  = r_line[j*DW +: DW];
            assign w_b  = w_hrow[j*DW +: DW];
            assign w_c  = '0;
            assign w_d  = '0;
        end
        uds_pix_alu #(.DW(DW)) u_v_alu (
            .i_op  (w_op),
            .i_a   (w_a),
            .i_b   (w_b),
            .i_c   (w_c),
            .i_d   (w_d),
            .o_res (w_vrow[j*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IN;
            r_row_cnt    <= '0;
            r_mode       <= UDS_DN_MAX;
            r_line       <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_pend       <= '0;
            r_pend_eof   <= 1'b0;
            r_flush_next <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IN: begin
                    if (w_accept) begin
                        r_frame_err <= w_restart;
                        r_mode      <= w_mode;
                        r_row_cnt   <= w_last ? '0 : w_row + 1'b1;
                        if (w_restart) r_line <= '0;
                        if (w_dn) begin
                            r_out_valid <= w_row[0];
                            if (w_row[0]) begin
                                r_out_data <= {{c_DNPAD{1'b0}}, w_dn_row};
                                r_out_eof  <= w_last;
                            end else begin
                                r_line <= {{(W*DW){1'b0}}, in_data};
                            end
                        end else if (!w_mode[0]) begin
                            r_out_valid  <= 1'b1;
                            r_out_data   <= w_near;
                            r_out_eof    <= 1'b0;
                            r_pend       <= w_near;
                            r_pend_eof   <= w_last;
                            r_flush_next <= 1'b0;
                            r_state      <= S_EMIT2;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_eof   <= 1'b0;
                            r_line      <= w_hrow;
                            if (w_row == '0) begin
                                r_out_data <= w_hrow;
                            end else begin
                                r_out_data   <= w_vrow;
                                r_pend       <= w_hrow;
                                r_pend_eof   <= 1'b0;
                                r_flush_next <= w_last;
                                r_state      <= S_EMIT2;
                            end
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_EMIT2: begin
                    if (out_ready) begin
                        r_out_data <= r_pend;
                        r_out_eof  <= r_pend_eof;
                        r_state    <= r_flush_next ? S_FLUSH : S_IN;
                    end
                end
                S_FLUSH: begin
                    // Bottom edge: the last horizontal row is repeated once more.
                    if (out_ready) begin
                        r_out_data <= r_pend;
                        r_out_eof  <= 1'b1;
                        r_state    <= S_IN;
                    end
                end
                default: r_state <= S_IN;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_eof   = r_out_eof;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uds_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uds_stream
//  Purpose  : Self-checking bench for uds_stream: behavioural row model with a
//             per-cycle compare process, plus literal checks of known tiles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uds_stream;
    import uds_pkg::*;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int BW = 2*W*DW;
`ifdef UDS_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct packed {
        logic [BW-1:0] data;
        logic          eof;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic        eof;
    } beat2_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      mode;
    logic            in_valid;
    logic            in_ready;
    logic            in_sof;
    logic [W*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [BW-1:0]   out_data;
    logic            out_eof;
    logic            frame_err;

    logic [1:0]  mode2;
    logic        in_valid2;
    logic        in_ready2;
    logic        in_sof2;
    logic [31:0] in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [63:0] out_data2;
    logic        out_eof2;
    logic        frame_err2;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;
    int ferr_seen = 0;

    beat_t  expq[$];
    beat_t  logq[$];
    beat2_t log2[$];
    int         mrow = 0;
    logic [1:0] mmode = 2'b00;
    logic       ferr_exp = 1'b0;
    int         prev_x[W];
    int         prev_h[2*W];

    always #5 clk = ~clk;

    uds_stream #(.DW(DW), .W(W), .H(H)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_eof(out_eof), .frame_err(frame_err)
    );

    uds_stream #(.DW(16), .W(2), .H(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_sof(in_sof2), .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_eof(out_eof2), .frame_err(frame_err2)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input logic [BW-1:0] d, input logic e);
        beat_t b;
        b.data = d;
        b.eof  = e;
        return b;
    endfunction

    function automatic int lp(input logic [BW-1:0] d, input int k);
        logic [BW-1:0] t;
        t = d >> (k*DW);
        return int'(t[DW-1:0]);
    endfunction

    function automatic logic [W*DW-1:0] ramp(input int base, input int step);
        logic [W*DW-1:0] r;
        int v;
        for (int c = 0; c < W; c++) begin
            v = base + step*c;
            r[c*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [W*DW-1:0] rnd_row();
        logic [W*DW-1:0] r;
        for (int c = 0; c < W; c++) begin
            case ($urandom_range(0, 3))
                0:       r[c*DW +: DW] = '0;
                1:       r[c*DW +: DW] = '1;
                default: r[c*DW +: DW] = DW'($urandom);
            endcase
        end
        return r;
    endfunction

    // Reference: what the tile rules say each accepted row must produce.
    task automatic model_accept();
        int x[W];
        int h[2*W];
        int v;
        int a, b, c, d;
        logic [BW-1:0] bo, bh;
        for (int i = 0; i < W; i++) x[i] = int'(in_data[i*DW +: DW]);
        if (in_sof && mrow != 0) begin
            ferr_exp = 1'b1;
            mrow = 0;
        end
        if (mrow == 0) mmode = mode;
        for (int i = 0; i < W; i++) begin
            h[2*i]   = x[i];
            h[2*i+1] = (i < W-1) ? (x[i] + x[i+1] + RND) / 2 : x[i];
        end
        bh = '0;
        for (int k = 0; k < 2*W; k++) bh[k*DW +: DW] = h[k][DW-1:0];
        bo = '0;
        if (mmode == UDS_DN_MAX || mmode == UDS_DN_AVG) begin
            if (mrow % 2 == 1) begin
                for (int k = 0; k < W/2; k++) begin
                    a = prev_x[2*k]; b = prev_x[2*k+1]; c = x[2*k]; d = x[2*k+1];
                    if (mmode == UDS_DN_MAX) begin
                        v = a;
                        if (b > v) v = b;
                        if (c > v) v = c;
                        if (d > v) v = d;
                    end else begin
                        v = (a + b + c + d + 2*RND) / 4;
                    end
                    bo[k*DW +: DW] = v[DW-1:0];
                end
                expq.push_back(mk(bo, mrow == H-1));
            end else begin
                prev_x = x;
            end
        end else if (mmode == UDS_UP_NEAR) begin
            for (int k = 0; k < 2*W; k++) bo[k*DW +: DW] = x[k/2][DW-1:0];
            expq.push_back(mk(bo, 1'b0));
            expq.push_back(mk(bo, mrow == H-1));
        end else begin
            if (mrow == 0) begin
                expq.push_back(mk(bh, 1'b0));
            end else begin
                for (int k = 0; k < 2*W; k++) begin
                    v = (prev_h[k] + h[k] + RND) / 2;
                    bo[k*DW +: DW] = v[DW-1:0];
                end
                expq.push_back(mk(bo, 1'b0));
                expq.push_back(mk(bh, 1'b0));
                if (mrow == H-1) expq.push_back(mk(bh, 1'b1));
            end
            prev_h = h;
        end
        mrow = (mrow + 1) % H;
    endtask

    // Compare process: every cycle, DUT outputs against the model's queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                mrow = 0;
                ferr_exp = 1'b0;
            end else begin
                chk("out_valid", BW'(out_valid), BW'(expq.size() != 0));
                chk("in_ready", BW'(in_ready),
                    BW'(expq.size() == 0 || (expq.size() == 1 && out_ready)));
                chk("frame_err", BW'(frame_err), BW'(ferr_exp));
                if (frame_err) ferr_seen++;
                if (out_valid && expq.size() != 0) begin
                    chk("out_data", out_data, expq[0].data);
                    chk("out_eof", BW'(out_eof), BW'(expq[0].eof));
                end
                ferr_exp = 1'b0;
                if (out_valid && out_ready && expq.size() != 0) begin
                    logq.push_back(mk(out_data, out_eof));
                    void'(expq.pop_front());
                end
                if (in_valid && in_ready) model_accept();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid2 && out_ready2) begin
                log2.push_back({out_data2, out_eof2});
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send_row(input logic sof, input logic [1:0] m, input logic [W*DW-1:0] d);
        int   n;
        logic acc;
        in_valid = 1'b1;
        in_sof   = sof;
        mode     = m;
        in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 500);
        chk("send_row_accepted", BW'(acc), BW'(1));
        in_valid = 1'b0;
        in_sof   = 1'b0;
        mode     = 2'($urandom);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send2(input logic sof, input logic [31:0] d);
        int   n;
        logic acc;
        in_valid2 = 1'b1;
        in_sof2   = sof;
        mode2     = UDS_UP_BILIN;
        in_data2  = d;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready2;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        chk("send2_accepted", BW'(acc), BW'(1));
        in_valid2 = 1'b0;
        in_sof2   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_time", BW'(n < 3000), BW'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int fe0;
        logic [1:0] m;
        logic s0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; mode = 2'b00; in_data = '0;
        in_valid2 = 1'b0; in_sof2 = 1'b0; mode2 = 2'b00; in_data2 = '0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", BW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_eof", BW'(out_eof), '0);
        chk("rst_frame_err", BW'(frame_err), '0);
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DN_MAX on a ramp image
        logq.delete();
        for (int r = 0; r < H; r++) send_row(r == 0, (r == 0) ? UDS_DN_MAX : 2'($urandom), ramp(r*8, 1));
        drain();
        chk("dnmax_beats", BW'(logq.size()), BW'(4));
        if (logq.size() == 4) begin
            chk("dnmax_b0p0", BW'(lp(logq[0].data, 0)), BW'(9));
            chk("dnmax_b3p3", BW'(lp(logq[3].data, 3)), BW'(63));
            chk("dnmax_b1p2", BW'(lp(logq[1].data, 2)), BW'(3*8+5));
            chk("dnmax_upper0", logq[0].data >> ((W/2)*DW), '0);
            chk("dnmax_eof3", BW'(logq[3].eof), BW'(1));
            chk("dnmax_eof2", BW'(logq[2].eof), BW'(0));
        end

        // DN_AVG with random out_ready
        rdy_mode = 2;
        logq.delete();
        send_row(1'b1, UDS_DN_AVG, ramp(1, 1));
        send_row(1'b0, UDS_UP_NEAR, ramp(3, 1));
        for (int r = 2; r < H; r++) send_row(1'b0, 2'($urandom), rnd_row());
        drain();
        chk("dnavg_beats", BW'(logq.size()), BW'(4));
        if (logq.size() != 0) chk("dnavg_p0", BW'(lp(logq[0].data, 0)), BW'(2 + RND));

        // UP_NEAR with out_ready toggling every cycle
        rdy_mode = 1;
        logq.delete();
        for (int r = 0; r < H; r++) send_row(r == 0, (r == 0) ? UDS_UP_NEAR : 2'($urandom), ramp(r*16, 1));
        drain();
        chk("near_beats", BW'(logq.size()), BW'(16));
        if (logq.size() == 16) begin
            chk("near_b15p15", BW'(lp(logq[15].data, 15)), BW'(119));
            chk("near_b2p3", BW'(lp(logq[2].data, 3)), BW'(17));
            chk("near_eof15", BW'(logq[15].eof), BW'(1));
            chk("near_eof13", BW'(logq[13].eof), BW'(0));
        end

        // UP_BILIN on the 2x2 instance
        log2.delete();
        send2(1'b1, {16'd4, 16'd0});
        send2(1'b0, {16'd12, 16'd8});
        repeat (10) @(posedge clk);
        #1;
        chk("bilin_beats", BW'(log2.size()), BW'(4));
        if (log2.size() == 4) begin
            chk("bilin_b1", BW'(log2[0]), BW'({16'd4, 16'd4, 16'd2, 16'd0, 1'b0}));
            chk("bilin_b2", BW'(log2[1]), BW'({16'd8, 16'd8, 16'd6, 16'd4, 1'b0}));
            chk("bilin_b3", BW'(log2[2]), BW'({16'd12, 16'd12, 16'd10, 16'd8, 1'b0}));
            chk("bilin_b4", BW'(log2[3]), BW'({16'd12, 16'd12, 16'd10, 16'd8, 1'b1}));
        end
        chk("bilin_no_ferr", BW'(frame_err2), '0);

        // in_sof at row 3 of a DN tile
        rdy_mode = 0;
        logq.delete();
        fe0 = ferr_seen;
        for (int r = 0; r < 3; r++) send_row(r == 0, UDS_DN_MAX, ramp(1000 + r, 0));
        send_row(1'b1, UDS_DN_MAX, ramp(100, 0));
        send_row(1'b0, UDS_DN_MAX, ramp(200, 0));
        for (int r = 2; r < H; r++) send_row(1'b0, UDS_DN_MAX, ramp(300 + r, 0));
        drain();
        chk("ferr_pulses", BW'(ferr_seen - fe0), BW'(1));
        chk("ferr_beats", BW'(logq.size()), BW'(5));
        if (logq.size() == 5) begin
            chk("ferr_old_p0", BW'(lp(logq[0].data, 0)), BW'(1001));
            chk("ferr_new_p0", BW'(lp(logq[1].data, 0)), BW'(200));
            chk("ferr_eof", BW'(logq[4].eof), BW'(1));
        end

        // Random tiles, random modes, occasional stray sof
        rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            m  = 2'($urandom);
            s0 = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < H; r++) begin
                send_row((r == 0) ? s0 : ($urandom_range(0, 15) == 0),
                         (r == 0) ? m : 2'($urandom), rnd_row());
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset while a beat is stuck on the output
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send_row(1'b1, UDS_UP_NEAR, ramp(7, 3));
        repeat (3) @(posedge clk);
        #2;
        chk("prerst_valid", BW'(out_valid), BW'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", BW'(out_valid), '0);
        chk("rst_async_data", out_data, '0);
        chk("rst_async_eof", BW'(out_eof), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_idle", BW'(out_valid), '0);
        rdy_mode = 2;
        for (int r = 0; r < H; r++) send_row(r == 0, (r == 0) ? UDS_UP_BILIN : 2'($urandom), rnd_row());
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
